// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and constants for the cacheline adaptor: line/beat geometry,
// FSM state encoding and the beat index type.
package cacheline_adaptor_pkg;
  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int ADDR_WIDTH  = 32;
  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam int BEAT_IDX_W  = $clog2(BEATS);

  typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

  localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_e;

  function automatic logic [ADDR_WIDTH-1:0] align_line(input logic [ADDR_WIDTH-1:0] addr);
    return {addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction
endpackage

// File: rtl/cacheline_adaptor_if.sv
// Line-side and pmem-side bus bundle; the adaptor uses the slave view,
// the requester/memory environment uses the master view.
interface cacheline_adaptor_if;
  import cacheline_adaptor_pkg::*;

  logic                   mem_read;
  logic                   mem_write;
  logic [ADDR_WIDTH-1:0]  mem_address;
  logic [LINE_WIDTH-1:0]  mem_wdata;
  logic [LINE_WIDTH-1:0]  mem_rdata;
  logic                   mem_resp;

  logic                   pmem_read;
  logic                   pmem_write;
  logic [ADDR_WIDTH-1:0]  pmem_address;
  logic [BURST_WIDTH-1:0] pmem_wdata;
  logic [BURST_WIDTH-1:0] pmem_rdata;
  logic                   pmem_resp;

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/cacheline_adaptor_line_beat_buffer.sv
// Line register plus beat counter: stores incoming beats, presents the
// current outgoing beat, loads a full line, and flags the last beat.
module line_beat_buffer
  import cacheline_adaptor_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   line_load,
  input  logic [LINE_WIDTH-1:0]  line_in,
  input  logic                   beat_adv,
  input  logic                   beat_store,
  input  logic [BURST_WIDTH-1:0] beat_in,
  output logic [BURST_WIDTH-1:0] beat_out,
  output logic [LINE_WIDTH-1:0]  line_next,
  output logic                   last_beat
);
  logic [LINE_WIDTH-1:0] line_q, line_d;
  beat_idx_t             cnt_q, cnt_d;

  // next line contents and beat index
  always_comb begin
    line_d = line_q;
    cnt_d  = cnt_q;
    if (line_load) begin
      line_d = line_in;
      cnt_d  = '0;
    end else if (beat_adv) begin
      if (beat_store) begin
        line_d[cnt_q*BURST_WIDTH +: BURST_WIDTH] = beat_in;
      end else begin
        line_d = line_q;
      end
      cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + beat_idx_t'(1);
    end else begin
      line_d = line_q;
      cnt_d  = cnt_q;
    end
  end

  // line and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else begin
      line_q <= line_d;
      cnt_q  <= cnt_d;
    end
  end

  assign beat_out  = line_q[cnt_q*BURST_WIDTH +: BURST_WIDTH];
  assign line_next = line_d;
  assign last_beat = (cnt_q == LAST_BEAT);
endmodule

// File: rtl/cacheline_adaptor.sv
// Line-to-burst adaptor: one 256-bit line request becomes a 4-beat 64-bit pmem burst.
// Optional ADAPTOR_PERF_CNT_EN adds rd_line_count / wr_line_count outputs.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  cacheline_adaptor_if.slave bus
`ifdef ADAPTOR_PERF_CNT_EN
  ,
  output logic [31:0] rd_line_count,
  output logic [31:0] wr_line_count
`endif
);
  // The beat buffer is shared by reads and writes; mem_rdata lives in its own
  // register, loaded only when a read burst completes, so writes never disturb it.
  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LINE_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    load_s, adv_s, store_s, last_s;
  logic [BURST_WIDTH-1:0]  beat_out_s;
  logic [LINE_WIDTH-1:0]   line_next_s;

  line_beat_buffer u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_load  (load_s),
    .line_in    (bus.mem_wdata),
    .beat_adv   (adv_s),
    .beat_store (store_s),
    .beat_in    (bus.pmem_rdata),
    .beat_out   (beat_out_s),
    .line_next  (line_next_s),
    .last_beat  (last_s)
  );

  // next state, address capture and read-line capture
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    load_s  = 1'b0;
    adv_s   = 1'b0;
    store_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_read) begin
          addr_d  = align_line(bus.mem_address);
          state_d = RD_BURST;
        end else if (bus.mem_write) begin
          addr_d  = align_line(bus.mem_address);
          load_s  = 1'b1;
          state_d = WR_BURST;
        end else begin
          state_d = IDLE;
        end
      end
      RD_BURST: begin
        if (bus.pmem_resp) begin
          adv_s   = 1'b1;
          store_s = 1'b1;
          if (last_s) begin
            rdata_d = line_next_s;
            state_d = DONE;
          end else begin
            state_d = RD_BURST;
          end
        end else begin
          state_d = RD_BURST;
        end
      end
      WR_BURST: begin
        if (bus.pmem_resp) begin
          adv_s = 1'b1;
          if (last_s) begin
            state_d = DONE;
          end else begin
            state_d = WR_BURST;
          end
        end else begin
          state_d = WR_BURST;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM, address and read-line registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.pmem_read    = (state_q == RD_BURST);
  assign bus.pmem_write   = (state_q == WR_BURST);
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = (state_q == WR_BURST) ? beat_out_s : '0;
  assign bus.mem_resp     = (state_q == DONE);
  assign bus.mem_rdata    = rdata_q;

`ifdef ADAPTOR_PERF_CNT_EN
  logic [31:0] rd_line_count_q, rd_line_count_d;
  logic [31:0] wr_line_count_q, wr_line_count_d;

  // completed-line counters, bumped on entry to DONE
  always_comb begin
    rd_line_count_d = rd_line_count_q;
    wr_line_count_d = wr_line_count_q;
    if (state_q == RD_BURST && state_d == DONE) begin
      rd_line_count_d = rd_line_count_q + 32'd1;
    end else if (state_q == WR_BURST && state_d == DONE) begin
      wr_line_count_d = wr_line_count_q + 32'd1;
    end else begin
      rd_line_count_d = rd_line_count_q;
      wr_line_count_d = wr_line_count_q;
    end
  end

  // counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_line_count_q <= 32'd0;
      wr_line_count_q <= 32'd0;
    end else begin
      rd_line_count_q <= rd_line_count_d;
      wr_line_count_q <= wr_line_count_d;
    end
  end

  assign rd_line_count = rd_line_count_q;
  assign wr_line_count = wr_line_count_q;
`endif
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor with a queue scoreboard for read lines
// and write beats; ADAPTOR_PERF_CNT_EN enables the counter checks.
module tb_cacheline_adaptor;
  import cacheline_adaptor_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cacheline_adaptor_if bus ();

`ifdef ADAPTOR_PERF_CNT_EN
  logic [31:0] rd_line_count, wr_line_count;
`endif

  cacheline_adaptor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ADAPTOR_PERF_CNT_EN
    ,
    .rd_line_count (rd_line_count),
    .wr_line_count (wr_line_count)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  logic [255:0] rd_exp_q[$];
  logic [63:0]  wbeat_q[$];
  logic [255:0] last_rd_line = 256'd0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: mem_rdata at each mem_resp, pmem_wdata at each accepted write beat
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.mem_resp === 1'b1) begin
      if (rd_exp_q.size() == 0) begin
        chk("spurious_mem_resp", 256'(bus.mem_resp), 256'd0);
      end else begin
        logic [255:0] e;
        e = rd_exp_q.pop_front();
        chk("mem_rdata", bus.mem_rdata, e);
      end
    end
    if (rst_n === 1'b1 && bus.pmem_write === 1'b1 && bus.pmem_resp === 1'b1) begin
      if (wbeat_q.size() == 0) begin
        chk("spurious_wbeat", 256'(bus.pmem_write), 256'd0);
      end else begin
        logic [63:0] w;
        w = wbeat_q.pop_front();
        chk("pmem_wdata", 256'(bus.pmem_wdata), 256'(w));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // One line transaction; pat gives pmem_resp per cycle (bit k-1 = cycle k),
  // lead = cycles before the burst starts, exp_lat = cycles until mem_resp.
  task automatic run_txn(input bit is_rd, input bit also_wr, input logic [31:0] addr,
                         input logic [255:0] line, input logic [15:0] pat, input int lead,
                         input int exp_lat, input bit hold, input string tag);
    int beats = 0;
    int lat = -1;
    bit lvl_ok = 1'b1;
    bit addr_ok = 1'b1;
    logic [31:0] exp_addr;
    exp_addr = {addr[31:5], 5'd0};
    if (is_rd) begin
      rd_exp_q.push_back(line);
      last_rd_line = line;
    end else begin
      for (int i = 0; i < 4; i++) wbeat_q.push_back(line[i*64 +: 64]);
      rd_exp_q.push_back(last_rd_line);
    end
    bus.mem_address = addr;
    bus.mem_read    = is_rd;
    bus.mem_write   = !is_rd || also_wr;
    bus.mem_wdata   = is_rd ? ~line : line;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.mem_resp === 1'b1) begin
        lat = k;
        break;
      end
      if (k > lead) begin
        if (bus.pmem_read !== is_rd || bus.pmem_write !== !is_rd) lvl_ok = 1'b0;
        if (bus.pmem_address !== exp_addr) addr_ok = 1'b0;
      end
      if (k == lead + 1) begin
        bus.mem_address = ~addr;
        bus.mem_wdata   = ~bus.mem_wdata;
      end
      if (beats >= 4) bus.pmem_resp = 1'b0;
      else if (k <= 16) bus.pmem_resp = pat[k-1];
      else bus.pmem_resp = 1'b1;
      if (beats < 4) bus.pmem_rdata = is_rd ? line[beats*64 +: 64] : 64'h0;
      if (bus.pmem_resp && k > lead) beats++;
    end
    bus.pmem_resp = 1'b0;
    chk({tag, "_latency"}, 256'(lat), 256'(exp_lat));
    chk({tag, "_pmem_level"}, 256'(lvl_ok), 256'd1);
    chk({tag, "_pmem_address"}, 256'(addr_ok), 256'd1);
    chk({tag, "_pmem_idle_in_done"}, 256'({bus.pmem_read, bus.pmem_write}), 256'd0);
    if (!hold) begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_single_resp"}, 256'(bus.mem_resp), 256'd0);
    end
  endtask

  localparam logic [255:0] L1 = {64'h4444444444444444, 64'h3333333333333333,
                                 64'h2222222222222222, 64'h1111111111111111};
  localparam logic [255:0] W1 = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                                 64'h0F1E2D3C4B5A6978, 64'h89ABCDEF01234567};

  initial begin
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.mem_address = 32'h0; bus.mem_wdata = 256'h0;
    bus.pmem_rdata = 64'h0; bus.pmem_resp = 1'b0;
    #2;
    chk("rst_pmem_rw", 256'({bus.pmem_read, bus.pmem_write}), 256'd0);
    chk("rst_mem_resp", 256'(bus.mem_resp), 256'd0);
    chk("rst_mem_rdata", bus.mem_rdata, 256'd0);
    chk("rst_pmem_address", 256'(bus.pmem_address), 256'd0);
    chk("rst_pmem_wdata", 256'(bus.pmem_wdata), 256'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: back-to-back read
    run_txn(1'b1, 1'b0, 32'h0000_1234, L1, 16'hFFFF, 0, 5, 1'b0, "rd1");
    // 2: write; mem_rdata must still show the read line
    run_txn(1'b0, 1'b0, 32'h8000_00E0, W1, 16'hFFFF, 0, 5, 1'b0, "wr1");
    chk("rdata_after_write", bus.mem_rdata, L1);
    // 3: read with pmem_resp gaps 1,0,0,1,1,0,1
    run_txn(1'b1, 1'b0, 32'h0000_2000, {4{64'hA5A5_0000_0000_0001}} ^ {64'd3, 64'd2, 64'd1, 64'd0},
            16'h0059, 0, 8, 1'b0, "rd_gap");

    // 4: reset after two beats of a read
    bus.mem_read = 1'b1; bus.mem_address = 32'h0000_3000;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      bus.pmem_resp = 1'b1; bus.pmem_rdata = 64'hDEAD_0000_0000_0000 + 64'(k);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_pmem_read", 256'(bus.pmem_read), 256'd0);
    chk("midrst_mem_resp", 256'(bus.mem_resp), 256'd0);
    chk("midrst_mem_rdata", bus.mem_rdata, 256'd0);
    last_rd_line = 256'd0;
    bus.pmem_resp = 1'b0; bus.mem_read = 1'b0;
    @(posedge clk); @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(1'b1, 1'b0, 32'h0000_3040, ~L1, 16'hFFFF, 0, 5, 1'b0, "rd_after_rst");

    // 5: read and write together, then a held read accepted right after DONE
    run_txn(1'b1, 1'b1, 32'h0000_4000, {W1[127:0], W1[255:128]}, 16'hFFFF, 0, 5, 1'b1, "rd_wr_both");
    run_txn(1'b1, 1'b0, 32'h0000_5000, L1 ^ W1, 16'hFFFF, 1, 6, 1'b0, "rd_held");

    run_txn(1'b0, 1'b0, 32'h0000_6000, ~W1, 16'h00F3, 0, 7, 1'b0, "wr_gap");
    run_txn(1'b0, 1'b0, 32'h0000_701F, W1 ^ L1, 16'hFFFF, 0, 5, 1'b0, "wr3");
    chk("rdata_after_writes", bus.mem_rdata, L1 ^ W1);

`ifdef ADAPTOR_PERF_CNT_EN
    // 6: three reads and two writes since the last reset, then wrap
    chk("rd_line_count", 256'(rd_line_count), 256'd3);
    chk("wr_line_count", 256'(wr_line_count), 256'd2);
    force dut.rd_line_count_q = 32'hFFFF_FFFF;
    force dut.wr_line_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.rd_line_count_q;
    release dut.wr_line_count_q;
    run_txn(1'b1, 1'b0, 32'h0000_8000, L1, 16'hFFFF, 0, 5, 1'b0, "rd_wrap");
    chk("rd_line_count_wrap", 256'(rd_line_count), 256'd0);
    chk("wr_line_count_hold", 256'(wr_line_count), 256'hFFFF_FFFF);
    run_txn(1'b0, 1'b0, 32'h0000_9000, W1, 16'hFFFF, 0, 5, 1'b0, "wr_wrap");
    chk("wr_line_count_wrap", 256'(wr_line_count), 256'd0);
`endif

    @(posedge clk); #1;
    chk("rd_queue_drained", 256'(rd_exp_q.size()), 256'd0);
    chk("wbeat_queue_drained", 256'(wbeat_q.size()), 256'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
